aoi_1: RTL and testbench

AOI_1 -- requirements
Module: aoi_1

---
 rtl/aoi_pkg.sv | 20 ++
 rtl/aoi_core.sv | 39 +++
 rtl/aoi_1.sv | 64 ++++++
 tb/tb_aoi_1.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/aoi_pkg.sv
// +----------------------------------------------------------------------+
// | aoi_pkg : shared gate-mode encodings for the AOI/OAI cell family      |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

package aoi_pkg;

  localparam int MODE_AOI22  = 0;
  localparam int MODE_AOI21  = 1;
  localparam int MODE_AOI211 = 2;
  localparam int MODE_OAI22  = 3;

  function automatic bit is_legal_mode(input int mode);
    return (mode >= MODE_AOI22) && (mode <= MODE_OAI22);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aoi_core.sv
// +----------------------------------------------------------------------+
// | aoi_core : bitwise combinational AOI22/AOI21/AOI211/OAI22 function    |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module aoi_core
  import aoi_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int MODE  = MODE_AOI22
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Y
);

  if (!is_legal_mode(MODE)) begin : g_illegal_mode
    $error("aoi_core: illegal MODE %0d", MODE);
  end

  if (MODE == MODE_AOI22) begin : g_aoi22
    assign Y = ~((A & B) | (C & D));
  end else if (MODE == MODE_AOI21) begin : g_aoi21
    // D is not part of the AOI21 function
    logic unused_d;
    assign unused_d = ^D;
    assign Y = ~((A & B) | C);
  end else if (MODE == MODE_AOI211) begin : g_aoi211
    assign Y = ~((A & B) | C | D);
  end else begin : g_oai22
    assign Y = ~((A | B) & (C | D));
  end

endmodule

`default_nettype wire

// File: rtl/aoi_1.sv
// +----------------------------------------------------------------------+
// | aoi_1 : AOI/OAI gate with registered copy and change flag             |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module aoi_1
  import aoi_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int MODE  = MODE_AOI22
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_Q,
  output logic             CHG
);

  logic [WIDTH-1:0] y_q_q, y_q_d;
  logic             chg_q, chg_d;

  aoi_core #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_core (
    .A (A),
    .B (B),
    .C (C),
    .D (D),
    .Y (Y)
  );

  always_comb begin
    y_q_d = y_q_q;
    chg_d = 1'b0;
    if (EN) begin
      y_q_d = Y;
      chg_d = (Y != y_q_q);
    end
  end

  // Reset value is the AOI22 output for all-zero inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q_q <= '1;
      chg_q <= 1'b0;
    end else begin
      y_q_q <= y_q_d;
      chg_q <= chg_d;
    end
  end

  assign Y_Q = y_q_q;
  assign CHG = chg_q;

endmodule

`default_nettype wire

// File: tb/tb_aoi_1.sv
// +----------------------------------------------------------------------+
// | tb_aoi_1 : self-checking bench for aoi_1, all modes plus WIDTH 1      |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_aoi_1;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] ia, ib, ic, id;

  logic [3:0] y_w  [4];
  logic [3:0] yq_w [4];
  logic       chg_w[4];
  logic       y1, yq1, chg1;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] m_yq [4];
  logic       m_chg[4];
  logic       m_yq1, m_chg1;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    aoi_1 #(.WIDTH(4), .MODE(m)) u_dut (
      .CLK (clk), .RST (rst), .EN (en),
      .A (ia), .B (ib), .C (ic), .D (id),
      .Y (y_w[m]), .Y_Q (yq_w[m]), .CHG (chg_w[m])
    );
  end

  aoi_1 #(.WIDTH(1), .MODE(0)) u_w1 (
    .CLK (clk), .RST (rst), .EN (en),
    .A (ia[0]), .B (ib[0]), .C (ic[0]), .D (id[0]),
    .Y (y1), .Y_Q (yq1), .CHG (chg1)
  );

  // Reference: count how many product terms are true; AOI output is 1 when none are
  function automatic logic [3:0] ref_y(input int m, input logic [3:0] a, b, c, d);
    logic [3:0] r;
    int hits;
    for (int i = 0; i < 4; i++) begin
      hits = 0;
      case (m)
        0: hits = int'(a[i] && b[i]) + int'(c[i] && d[i]);
        1: hits = int'(a[i] && b[i]) + int'(c[i]);
        2: hits = int'(a[i] && b[i]) + int'(c[i]) + int'(d[i]);
        default: hits = ((a[i] || b[i]) && (c[i] || d[i])) ? 1 : 0;
      endcase
      r[i] = (hits == 0);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] a, b, c, d);
    logic [3:0] ey [4];
    logic       ey1;
    @(negedge clk);
    rst = r; en = e; ia = a; ib = b; ic = c; id = d;
    #1;
    for (int m = 0; m < 4; m++) begin
      ey[m] = ref_y(m, a, b, c, d);
      chk($sformatf("Y_mode%0d", m), y_w[m], ey[m]);
    end
    ey1 = ey[0][0];
    chk("Y_w1", {3'b0, y1}, {3'b0, ey1});
    @(posedge clk);
    for (int m = 0; m < 4; m++) begin
      if (r) begin
        m_yq[m] = 4'hF; m_chg[m] = 1'b0;
      end else if (e) begin
        m_chg[m] = (ey[m] != m_yq[m]); m_yq[m] = ey[m];
      end else begin
        m_chg[m] = 1'b0;
      end
    end
    if (r) begin
      m_yq1 = 1'b1; m_chg1 = 1'b0;
    end else if (e) begin
      m_chg1 = (ey1 != m_yq1); m_yq1 = ey1;
    end else begin
      m_chg1 = 1'b0;
    end
    #1;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("YQ_mode%0d", m), yq_w[m], m_yq[m]);
      chk($sformatf("CHG_mode%0d", m), {3'b0, chg_w[m]}, {3'b0, m_chg[m]});
    end
    chk("YQ_w1", {3'b0, yq1}, {3'b0, m_yq1});
    chk("CHG_w1", {3'b0, chg1}, {3'b0, m_chg1});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ia = '0; ib = '0; ic = '0; id = '0;

    // Reset state
    step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("reset_yq_w1", {3'b0, yq1}, 4'b0001);
    chk("reset_chg_w1", {3'b0, chg1}, 4'b0000);
    chk("reset_yq_m3", yq_w[3], 4'hF);

    // All-zero then A=0,B=C=D=1 after 100 ns
    step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("r28_y_zero", {3'b0, y1}, 4'b0001);
    #100;
    step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 4'hF);
    chk("r28_y_0111", {3'b0, y1}, 4'b0000);

    // Exhaustive WIDTH-1 AOI22 truth table, captured every cycle
    for (int k = 0; k < 16; k++) begin
      logic [3:0] v;
      v = k[3:0];
      step(1'b0, 1'b1, {4{v[3]}}, {4{v[2]}}, {4{v[1]}}, {4{v[0]}});
      chk($sformatf("r29_tt%0d", k), {3'b0, y1},
          {3'b0, !((v[3] && v[2]) || (v[1] && v[0]))});
    end

    // Reset, capture A=B=1, then hold the same inputs
    step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0);
    chk("r30_yq_cap", {3'b0, yq1}, 4'b0000);
    chk("r30_chg_cap", {3'b0, chg1}, 4'b0001);
    step(1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0);
    chk("r30_chg_same", {3'b0, chg1}, 4'b0000);

    // EN low: Y follows, Y_Q holds
    step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("r31_y_follow", {3'b0, y1}, 4'b0001);
    chk("r31_yq_hold", {3'b0, yq1}, 4'b0000);
    chk("r31_chg", {3'b0, chg1}, 4'b0000);
    step(1'b0, 1'b0, 4'h5, 4'hA, 4'h3, 4'hC);

    // Reset beats a pending capture of Y=0
    step(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
    step(1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
    chk("r32_yq", {3'b0, yq1}, 4'b0001);
    chk("r32_yq_m0", yq_w[0], 4'hF);

    // WIDTH 4 OAI22 directed vector
    step(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0011, 4'b0000);
    chk("r33_oai22", y_w[3], 4'b1110);

    // Random stimulus with occasional reset and enable toggling
    for (int k = 0; k < 200; k++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    // Unknown EN must not disturb Y
    @(negedge clk);
    en = 1'bx; ia = 4'hC; ib = 4'h6; ic = 4'h9; id = 4'h3; rst = 1'b0;
    #1;
    for (int m = 0; m < 4; m++)
      chk($sformatf("enx_Y_mode%0d", m), y_w[m], ref_y(m, 4'hC, 4'h6, 4'h9, 4'h3));
    step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
